// File: rtl/dm_pkg.sv
// dm_pkg: shared types and helpers for the dm_responder slice.
//   ADDR_W / DATA_W  : byte-address and data widths
//   stateT           : responder FSM states
//   sizeT            : access size encodings
//   reqT             : request fields captured when a request is accepted
package dm_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        MERGE,
        RESP
    } stateT;

    typedef enum logic [1:0] {
        WORD = 2'd0,
        HALF = 2'd1,
        BYTE = 2'd2
    } sizeT;

    typedef struct packed {
        logic              we;
        sizeT              size;
        logic              unsign;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } reqT;

    // Byte wins when both size strobes are set.
    function automatic sizeT decodeSize(input logic half, input logic byteSel);
        if (byteSel)   return BYTE;
        else if (half) return HALF;
        else           return WORD;
    endfunction

    function automatic logic isMisaligned(input sizeT size, input logic [1:0] offs);
        case (size)
            HALF:    return offs[0];
            WORD:    return (offs != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: combinational byte-lane handling for sub-word accesses.
//   size/offs/unsign : captured access size, addr[1:0] and extension mode
//   rdWord           : word currently read from the array (load extraction)
//   bufWord          : word buffered in ACCESS (store merge base)
//   wdata            : store data, sub-word data taken from its low bits
//   loadData         : extracted and sign/zero-extended load value
//   mergeData        : bufWord with only the addressed lanes replaced
// Lanes are little-endian: byte k lives in bits [8k+7:8k].
module dm_lane_unit
    import dm_pkg::*;
(
    input  sizeT              size,
    input  logic [1:0]        offs,
    input  logic              unsign,
    input  logic [DATA_W-1:0] rdWord,
    input  logic [DATA_W-1:0] bufWord,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] loadData,
    output logic [DATA_W-1:0] mergeData
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte = rdWord[{offs, 3'b000} +: 8];
        laneHalf = rdWord[{offs[1], 4'b0000} +: 16];
        case (size)
            BYTE:    loadData = {{24{~unsign & laneByte[7]}}, laneByte};
            HALF:    loadData = {{16{~unsign & laneHalf[15]}}, laneHalf};
            default: loadData = rdWord;
        endcase
    end

    always_comb begin
        mergeData = bufWord;
        case (size)
            BYTE:    mergeData[{offs, 3'b000} +: 8]     = wdata[7:0];
            HALF:    mergeData[{offs[1], 4'b0000} +: 16] = wdata[15:0];
            default: mergeData = wdata;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: single-port data-memory responder with configurable wait
// states and byte/half/word loads and stores.
//   clk, rst          : clock, synchronous active-low reset
//   req               : access request, only sampled in IDLE
//   we                : 1 = store, 0 = load
//   half, byteSel     : access size (byteSel has priority; neither = word).
//                       "byte" is a reserved word, hence the byteSel name.
//   unsign            : zero-extend sub-word loads when set
//   addr, wdata       : byte address and store data
//   rdata             : registered load result, held between responses
//   ready             : one-cycle completion pulse
//   err               : misalignment flag, only meaningful with ready
// Parameters: WAIT_STATES (0..7 idle cycles before the access),
//             DEPTH_WORDS (array depth, >= 2; word indices wrap modulo it).
module dm_responder
    import dm_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH_WORDS = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              half,
    input  logic              byteSel,
    input  logic              unsign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    stateT             state, nextState;
    reqT               capReq;
    logic [2:0]        waitCnt;
    logic [DATA_W-1:0] bufWord;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  wordIdx;
    logic [DATA_W-1:0] memRd;
    logic [DATA_W-1:0] loadData, mergeData;
    logic              memWe;
    logic [DATA_W-1:0] memWdata;
    sizeT              reqSize;
    logic              reqMisaligned;

    assign wordIdx       = IDX_W'(32'(capReq.addr[ADDR_W-1:2]) % 32'(DEPTH_WORDS));
    assign memRd         = mem[wordIdx];
    assign reqSize       = decodeSize(half, byteSel);
    assign reqMisaligned = isMisaligned(reqSize, addr[1:0]);

    dm_lane_unit laneUnit (
        .size      (capReq.size),
        .offs      (capReq.addr[1:0]),
        .unsign    (capReq.unsign),
        .rdWord    (memRd),
        .bufWord   (bufWord),
        .wdata     (capReq.wdata),
        .loadData  (loadData),
        .mergeData (mergeData)
    );

    always_comb begin
        nextState = state;
        memWe     = 1'b0;
        memWdata  = capReq.wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    // Misaligned requests never touch the array.
                    if (reqMisaligned)         nextState = RESP;
                    else if (WAIT_STATES == 0) nextState = ACCESS;
                    else                       nextState = WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == WAIT_LAST) nextState = ACCESS;
            end
            ACCESS: begin
                if (capReq.we && capReq.size != WORD) begin
                    nextState = MERGE;
                end else begin
                    nextState = RESP;
                    memWe     = capReq.we;
                end
            end
            MERGE: begin
                memWe     = 1'b1;
                memWdata  = mergeData;
                nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            ready <= (nextState == RESP);
            err   <= (state == IDLE) && (nextState == RESP);

            if (state == IDLE)      waitCnt <= '0;
            else if (state == WAIT) waitCnt <= waitCnt + 3'd1;

            // Load value is extracted straight from the array read in ACCESS
            // so it is in place by the time ready rises.
            if (state == IDLE && nextState == RESP)  rdata <= '0;
            else if (state == ACCESS && !capReq.we)  rdata <= loadData;
        end
    end

    // Request capture and merge buffer carry no reset: they are only
    // consumed after being written in IDLE/ACCESS.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            capReq <= '{we: we, size: reqSize, unsign: unsign, addr: addr, wdata: wdata};
        end
        if (state == ACCESS) bufWord <= memRd;
    end

    // Array is deliberately outside reset; a store whose write edge sees
    // rst low is dropped.
    always_ff @(posedge clk) begin
        if (rst && memWe) mem[wordIdx] <= memWdata;
    end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0, half = 1'b0, byteSel = 1'b0, unsign = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready, err;

    logic        req0 = 1'b0, we0 = 1'b0, half0 = 1'b0, byteSel0 = 1'b0, unsign0 = 1'b0;
    logic [6:0]  addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [31:0] rdata0;
    logic        ready0, err0;

    dm_responder #(.WAIT_STATES(W), .DEPTH_WORDS(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .half(half), .byteSel(byteSel),
        .unsign(unsign), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
    );

    dm_responder #(.WAIT_STATES(0), .DEPTH_WORDS(16)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .half(half0), .byteSel(byteSel0),
        .unsign(unsign0), .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCmp = 0, nBad = 0;

    // Behavioural model state
    logic [31:0] mdl [32];
    int          readyAt = -1;
    bit          errExp = 0, pendUpd = 0, chkOn = 0;
    logic [31:0] pendRdata = '0, mRdata = '0;
    int          lastReadyCyc = -1, tIssue = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mExtract(input logic [31:0] w, input int sz,
                                             input logic [1:0] a, input bit u);
        logic [31:0] v;
        if (sz == 0) return w;
        if (sz == 2) begin
            v = (w >> (8 * int'(a))) & 32'hFF;
            if (!u) v = (v ^ 32'h80) - 32'h80;
        end else begin
            v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!u) v = (v ^ 32'h8000) - 32'h8000;
        end
        return v;
    endfunction

    function automatic logic [31:0] mMerge(input logic [31:0] w, input int sz,
                                           input logic [1:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        mask = (sz == 2) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 2) ? 8 * int'(a) : 16 * int'(a[1]);
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    // Compare process: every cycle once enabled
    always @(negedge clk) begin
        if (chkOn) begin
            if (cyc == readyAt && pendUpd) mRdata = pendRdata;
            if (ready) lastReadyCyc = cyc;
            chk("ready", 32'(ready), 32'(cyc == readyAt));
            chk("err", 32'(err), 32'(cyc == readyAt && errExp));
            chk("rdata", rdata, mRdata);
        end
    end

    // sz: 0 word, 1 half, 2 byte, 3 byte with half also set
    task automatic issue(input bit w, input int sz, input bit u, input logic [6:0] a,
                         input logic [31:0] d);
        int s, idx, lat;
        bit mis;
        s   = (sz == 3) ? 2 : sz;
        idx = int'(a[6:2]);
        mis = (s == 1 && a[0]) || (s == 0 && a[1:0] != 2'b00);
        tIssue = cyc;
        req = 1'b1; we = w; half = (sz == 1 || sz == 3); byteSel = (sz >= 2);
        unsign = u; addr = a; wdata = d;
        if (mis)              lat = 1;
        else if (w && s != 0) lat = W + 3;
        else                  lat = W + 2;
        errExp    = mis;
        pendUpd   = mis || !w;
        pendRdata = mis ? 32'h0 : mExtract(mdl[idx], s, a[1:0], u);
        readyAt   = cyc + lat;
        @(posedge clk); #1;
        // Scramble the inputs once captured; the request must be unaffected.
        req = 1'b0; we = 1'($urandom); half = 1'($urandom); byteSel = 1'($urandom);
        unsign = 1'($urandom); addr = 7'($urandom); wdata = $urandom;
        if (!mis && w) mdl[idx] = (s == 0) ? d : mMerge(mdl[idx], s, a[1:0], d);
        while (cyc <= readyAt) begin @(posedge clk); #1; end
    endtask

    // Back-to-back vectors for the zero-wait, 16-deep instance
    logic [6:0]  va [5] = '{7'h40, 7'h04, 7'h00, 7'h44, 7'h03};
    logic        vw [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vb [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vd [5] = '{32'h89ABCDEF, 32'h00000055, 32'h0, 32'h0, 32'h0};
    logic [31:0] ve [5] = '{32'h0, 32'h0, 32'h89ABCDEF, 32'h00000055, 32'hFFFFFF89};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        @(posedge clk); #1;
        readyAt = -1; mRdata = '0; chkOn = 1;
        @(posedge clk); #1;
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b1;

        issue(1, 0, 0, 7'h10, 32'hDEADBEEF);
        chk("lat_word_store", 32'(lastReadyCyc - tIssue), 32'd3);
        issue(1, 0, 0, 7'h20, 32'hCAFEF00D);
        issue(1, 0, 0, 7'h24, 32'h80FF7F01);
        issue(1, 0, 0, 7'h7C, 32'h12345678);
        issue(0, 0, 0, 7'h10, 32'h0);
        chk("lat_word_load", 32'(lastReadyCyc - tIssue), 32'd3);
        chk("lit_word", rdata, 32'hDEADBEEF);

        issue(1, 2, 0, 7'h11, 32'hFFFFFF80);
        chk("lat_byte_store", 32'(lastReadyCyc - tIssue), 32'd4);
        issue(0, 0, 0, 7'h10, 32'h0);
        chk("lit_byte_merge", rdata, 32'hDEAD80EF);
        issue(0, 2, 0, 7'h11, 32'h0);
        chk("lit_byte_signed", rdata, 32'hFFFFFF80);
        issue(0, 2, 1, 7'h11, 32'h0);
        chk("lit_byte_unsigned", rdata, 32'h00000080);

        issue(1, 1, 0, 7'h12, 32'hABCD1234);
        chk("lat_half_store", 32'(lastReadyCyc - tIssue), 32'd4);
        issue(0, 1, 0, 7'h12, 32'h0);
        chk("lit_half_signed", rdata, 32'h00001234);
        issue(0, 1, 0, 7'h10, 32'h0);
        chk("lit_half_neg", rdata, 32'hFFFF80EF);
        issue(0, 1, 1, 7'h10, 32'h0);

        issue(0, 2, 0, 7'h24, 32'h0);
        issue(0, 2, 0, 7'h25, 32'h0);
        issue(0, 2, 0, 7'h26, 32'h0);
        chk("lit_byte_lane2", rdata, 32'hFFFFFFFF);
        issue(0, 2, 1, 7'h27, 32'h0);
        issue(1, 3, 0, 7'h27, 32'h000000AB);
        issue(0, 0, 0, 7'h24, 32'h0);
        chk("lit_byte_priority", rdata, 32'hABFF7F01);

        issue(0, 0, 0, 7'h13, 32'h0);
        chk("lat_misaligned", 32'(lastReadyCyc - tIssue), 32'd1);
        issue(1, 1, 0, 7'h11, 32'h0000FFFF);
        issue(1, 0, 0, 7'h16, 32'h11111111);
        issue(0, 0, 0, 7'h10, 32'h0);
        chk("lit_after_misaligned", rdata, 32'h123480EF);
        issue(0, 0, 0, 7'h7C, 32'h0);

        // Reset during WAIT of a word store to 0x20
        issue(0, 0, 0, 7'h20, 32'h0);
        req = 1'b1; we = 1'b1; half = 1'b0; byteSel = 1'b0; unsign = 1'b0;
        addr = 7'h20; wdata = 32'h5;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        readyAt = -1; mRdata = '0;
        chk("rst_mid_rdata", rdata, 32'h0);
        chk("rst_mid_ready", 32'(ready), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(0, 0, 0, 7'h20, 32'h0);
        chk("lit_rst_kept", rdata, 32'hCAFEF00D);

        // Zero wait states, req held high: 3-cycle cadence, index wrap at 16
        for (int k = 0; k < 5; k++) begin
            req0 = 1'b1; we0 = vw[k]; half0 = 1'b0; byteSel0 = vb[k];
            unsign0 = 1'b0; addr0 = va[k]; wdata0 = vd[k];
            for (int p = 0; p < 3; p++) begin
                @(negedge clk);
                chk("b2b_ready", 32'(ready0), 32'(p == 2));
                if (p == 2) chk("b2b_err", 32'(err0), 32'h0);
                if (p == 2 && !vw[k]) chk("b2b_rdata", rdata0, ve[k]);
                @(posedge clk); #1;
                if (k == 4 && p == 0) req0 = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            chk("b2b_idle", 32'(ready0), 32'h0);
        end

        chkOn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, meaning the number of idle cycles inserted before the array access (0..7).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 32, meaning the number of 32-bit words in the storage array.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 The block SHALL have port we  input  1  1=store, 0=load.
REQ-007 The block SHALL have ports half and byte  input  1 each  access size; neither set means word, byte has priority over half.
REQ-008 The block SHALL have port unsign  input  1  sub-word loads zero-extend when 1, sign-extend when 0.
REQ-009 The block SHALL have port addr  input  7  byte address; word index is addr[6:2].
REQ-010 The block SHALL have port wdata  input  32  store data; sub-word data is taken from its low bits.
REQ-011 The block SHALL have port rdata  output  32  load result, registered.
REQ-012 The block SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port err  output  1  misalignment flag, valid only while ready=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, ACCESS, MERGE and RESP.
REQ-015 In IDLE with req=1, the block SHALL register we/size/unsign/addr/wdata and then enter WAIT, or ACCESS when WAIT_STATES=0.
REQ-016 Once a request is captured, later changes on the request inputs SHALL NOT affect it.
REQ-017 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 3-bit counter cleared on entry.
REQ-018 ACCESS SHALL read the addressed word into a buffer; a word store SHALL write the array in this cycle.
REQ-019 A sub-word store SHALL go ACCESS->MERGE; MERGE SHALL write the buffer with only the addressed lanes replaced.
REQ-020 Byte lanes are little-endian: byte k occupies bits [8k+7:8k], and a halfword at addr[1] occupies lanes {2*addr[1]+1, 2*addr[1]}.
REQ-021 RESP SHALL assert ready=1 for exactly one cycle, then return to IDLE; req SHALL NOT be sampled in RESP.
REQ-022 Latency, with req accepted at cycle t and W=WAIT_STATES, SHALL be: ready at t+W+2 for loads and word stores, and at t+W+3 for sub-word stores.
REQ-023 A load SHALL update rdata with the extracted, extended value in RESP; rdata SHALL hold between responses, and stores SHALL leave it unchanged.
REQ-024 A misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) SHALL go IDLE->RESP directly with err=1 and ready=1 at t+1, rdata=0, and no array write.
REQ-025 Word indices >= DEPTH_WORDS SHALL wrap modulo DEPTH_WORDS.

Reset
REQ-026 When rst=0 at a clock edge: state=IDLE, ready=0, err=0, rdata=0, wait counter=0.
REQ-027 Reset mid-operation SHALL abandon the access; a store not yet written (before its ACCESS/MERGE write edge) SHALL leave the array unchanged.
REQ-028 Reset SHALL NOT clear the storage array.

Structure
REQ-029 Package dm_pkg SHALL hold the FSM state enumeration, size encodings (WORD/HALF/BYTE) and ADDR_W=7.
REQ-030 Lane extraction/extension and lane merging SHALL live in one combinational sub-module, dm_lane_unit.

Verification
REQ-031 Word store 0xDEADBEEF at addr 0x10 followed by word load at 0x10, W=1 -> ready at t+3 each, rdata=0xDEADBEEF.
REQ-032 Byte store 0x80 at 0x11 onto 0xDEADBEEF -> word reads 0xDEAD80EF; signed byte load at 0x11 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 Half store 0x1234 at 0x12, then signed half load at 0x12 -> rdata=0x00001234; sub-word store ready at t+4.
REQ-034 Word load at 0x13 -> ready and err at t+1, rdata=0, array unchanged.
REQ-035 rst=0 asserted during the WAIT of a word store of 0x5 to 0x20 -> outputs zero, word at 0x20 retains its prior value.
REQ-036 With W=0, back-to-back req held high -> requests complete on a 3-cycle cadence with no request dropped.
